// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
package clk_div_pkg;

    localparam int unsigned DIV_W_DEFAULT = 8;
    localparam int unsigned DEFAULT_DIV   = 8;

    // Number of high cycles per period; odd divisors get the extra cycle high.
    function automatic int unsigned half_high(input int unsigned d);
        return (d + 1) >> 1;
    endfunction

endpackage

// File: rtl/clk_div_multi_if.sv
// Control/status bundle for clk_div_multi: per-channel enables, divisor writes and outputs.
interface clk_div_multi_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DIV_W  = 8
);

    logic [NUM_CH-1:0]       en;
    logic [NUM_CH*DIV_W-1:0] div_in;
    logic [NUM_CH-1:0]       div_we;
    logic                    sync;
    logic [NUM_CH-1:0]       clk_out;
    logic [NUM_CH-1:0]       tick;
    logic [NUM_CH-1:0]       busy;

    modport master (
        output en, div_in, div_we, sync,
        input  clk_out, tick, busy
    );

    modport slave (
        input  en, div_in, div_we, sync,
        output clk_out, tick, busy
    );

endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: shadowed divisor, period counter, registered waveform and tick.
module clk_div_chan #(
    parameter int unsigned DIV_W       = clk_div_pkg::DIV_W_DEFAULT,
    parameter int unsigned DEFAULT_DIV = clk_div_pkg::DEFAULT_DIV
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [DIV_W-1:0] div_in,
    input  logic             div_we,
    input  logic             sync,
    output logic             clk_out,
    output logic             tick,
    output logic             busy
);
    import clk_div_pkg::*;

    localparam logic [DIV_W-1:0] One      = DIV_W'(1);
    localparam logic [DIV_W-1:0] RstDiv   = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] RstCnt   = DIV_W'(DEFAULT_DIV - 1);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] active_q, active_d;
    logic [DIV_W-1:0] shadow_q, shadow_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic             busy_q, busy_d;
    logic [DIV_W-1:0] load_div;
    logic [DIV_W-1:0] end_pos;

    always_comb begin
        // A same-cycle write bypasses the shadow so it can load on this very edge.
        load_div  = div_we ? div_in : shadow_q;
        // Parking at the last position makes the next enabled edge a boundary.
        end_pos   = (load_div == '0) ? '0 : load_div - One;
        shadow_d  = load_div;
        active_d  = active_q;
        cnt_d     = cnt_q;
        tick_d    = 1'b0;
        clk_out_d = 1'b0;

        if (!en) begin
            active_d = load_div;
            cnt_d    = end_pos;
        end else if (active_q == '0) begin
            active_d = load_div;
            cnt_d    = end_pos;
        end else if (sync || (cnt_q == active_q - One)) begin
            active_d = load_div;
            cnt_d    = '0;
            if (load_div != '0) begin
                tick_d    = 1'b1;
                clk_out_d = 1'b1;
            end
        end else begin
            cnt_d     = cnt_q + One;
            clk_out_d = 32'(cnt_d) < half_high(32'(active_q));
        end

        busy_d = (shadow_d != active_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= RstCnt;
            active_q  <= RstDiv;
            shadow_q  <= RstDiv;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            active_q  <= active_d;
            shadow_q  <= shadow_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
            busy_q    <= busy_d;
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;
    assign busy    = busy_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock-enable divider; channels share only clk, reset and sync.
module clk_div_multi #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned DIV_W       = clk_div_pkg::DIV_W_DEFAULT,
    parameter int unsigned DEFAULT_DIV = clk_div_pkg::DEFAULT_DIV
) (
    input  logic          clk,
    input  logic          reset,
    clk_div_multi_if.slave bus
);
    import clk_div_pkg::*;

    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] busy;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        clk_div_chan #(
            .DIV_W      (DIV_W),
            .DEFAULT_DIV(DEFAULT_DIV)
        ) u_chan (
            .clk    (clk),
            .reset  (reset),
            .en     (bus.en[i]),
            .div_in (bus.div_in[i*DIV_W +: DIV_W]),
            .div_we (bus.div_we[i]),
            .sync   (bus.sync),
            .clk_out(clk_out[i]),
            .tick   (tick[i]),
            .busy   (busy[i])
        );
    end

    assign bus.clk_out = clk_out;
    assign bus.tick    = tick;
    assign bus.busy    = busy;

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed self-checking bench for clk_div_multi.
module tb_clk_div_multi;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned DIV_W  = 8;

    logic clk = 1'b0;
    logic reset;
    int   cmp_cnt = 0;
    int   err_cnt = 0;

    clk_div_multi_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) dut_if ();

    clk_div_multi #(
        .NUM_CH     (NUM_CH),
        .DIV_W      (DIV_W),
        .DEFAULT_DIV(8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (dut_if)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_div(input int ch, input int d);
        dut_if.div_we[ch] = 1'b1;
        dut_if.div_in[ch*DIV_W +: DIV_W] = DIV_W'(d);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        dut_if.en = '0;
        dut_if.div_in = '0;
        dut_if.div_we = '0;
        dut_if.sync = 1'b0;
        step();
        step();
        cmp_cnt++;
        if ({dut_if.clk_out, dut_if.tick, dut_if.busy} !== 12'h000) begin
            err_cnt++;
            $display("FAIL reset_outputs got %h want 000",
                     {dut_if.clk_out, dut_if.tick, dut_if.busy});
        end
        reset = 1'b0;
        step();
        cmp_cnt++;
        if ({dut_if.clk_out, dut_if.tick, dut_if.busy} !== 12'h000) begin
            err_cnt++;
            $display("FAIL idle_after_reset got %h want 000",
                     {dut_if.clk_out, dut_if.tick, dut_if.busy});
        end
    endtask

    task automatic test_div8();
        logic [1:0] exp;
        dut_if.en[0] = 1'b1;
        for (int k = 0; k < 16; k++) begin
            step();
            exp = {(k % 8) < 4, (k % 8) == 0};
            cmp_cnt++;
            if ({dut_if.clk_out[0], dut_if.tick[0]} !== exp) begin
                err_cnt++;
                $display("FAIL div8 k=%0d got %b want %b", k,
                         {dut_if.clk_out[0], dut_if.tick[0]}, exp);
            end
        end
        dut_if.en[0] = 1'b0;
        step();
        cmp_cnt++;
        if ({dut_if.clk_out[0], dut_if.tick[0]} !== 2'b00) begin
            err_cnt++;
            $display("FAIL div8_disable got %b want 00", {dut_if.clk_out[0], dut_if.tick[0]});
        end
    endtask

    task automatic test_div5();
        logic [2:0] exp;
        dut_if.en[1] = 1'b1;
        step();
        cmp_cnt++;
        if (dut_if.tick[1] !== 1'b1) begin
            err_cnt++;
            $display("FAIL div5_first_tick got %b want 1", dut_if.tick[1]);
        end
        write_div(1, 5);
        step();
        dut_if.div_we = '0;
        cmp_cnt++;
        if ({dut_if.clk_out[1], dut_if.tick[1], dut_if.busy[1]} !== 3'b101) begin
            err_cnt++;
            $display("FAIL div5_pending got %b want 101",
                     {dut_if.clk_out[1], dut_if.tick[1], dut_if.busy[1]});
        end
        for (int k = 2; k < 8; k++) begin
            step();
            exp = {k < 4, 1'b0, 1'b1};
            cmp_cnt++;
            if ({dut_if.clk_out[1], dut_if.tick[1], dut_if.busy[1]} !== exp) begin
                err_cnt++;
                $display("FAIL div5_old_period k=%0d got %b want %b", k,
                         {dut_if.clk_out[1], dut_if.tick[1], dut_if.busy[1]}, exp);
            end
        end
        for (int k = 0; k < 10; k++) begin
            step();
            exp = {(k % 5) < 3, (k % 5) == 0, 1'b0};
            cmp_cnt++;
            if ({dut_if.clk_out[1], dut_if.tick[1], dut_if.busy[1]} !== exp) begin
                err_cnt++;
                $display("FAIL div5_new_period k=%0d got %b want %b", k,
                         {dut_if.clk_out[1], dut_if.tick[1], dut_if.busy[1]}, exp);
            end
        end
        dut_if.en[1] = 1'b0;
        step();
    endtask

    task automatic test_mid_update();
        logic [2:0] exp;
        logic       hist [20];
        int         exp_runs [10] = '{4, 4, 2, 1, 2, 1, 2, 1, 2, 1};
        int         run;
        int         idx;
        int         j;
        dut_if.en[0] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            if (k < 8) begin
                exp = {k < 4, k == 0, (k >= 3)};
            end else begin
                j = (k - 8) % 3;
                exp = {j < 2, j == 0, 1'b0};
            end
            hist[k] = dut_if.clk_out[0];
            cmp_cnt++;
            if ({dut_if.clk_out[0], dut_if.tick[0], dut_if.busy[0]} !== exp) begin
                err_cnt++;
                $display("FAIL mid_update k=%0d got %b want %b", k,
                         {dut_if.clk_out[0], dut_if.tick[0], dut_if.busy[0]}, exp);
            end
            if (k == 2) write_div(0, 3);
            if (k == 3) dut_if.div_we = '0;
        end
        run = 1;
        idx = 0;
        for (int k = 1; k <= 20; k++) begin
            if (k < 20 && hist[k] === hist[k-1]) begin
                run++;
            end else begin
                cmp_cnt++;
                if (idx >= 10 || run != exp_runs[idx]) begin
                    err_cnt++;
                    $display("FAIL run_length idx=%0d got %0d want %0d", idx, run,
                             (idx < 10) ? exp_runs[idx] : 0);
                end
                idx++;
                run = 1;
            end
        end
        dut_if.en[0] = 1'b0;
        step();
    endtask

    task automatic test_sync();
        logic [2:0] exp;
        write_div(0, 8);
        write_div(2, 4);
        step();
        dut_if.div_we = '0;
        dut_if.en[0] = 1'b1;
        step();
        step();
        step();
        dut_if.en[2] = 1'b1;
        step();
        step();
        cmp_cnt++;
        if ({dut_if.tick[0], dut_if.tick[2]} !== 2'b00) begin
            err_cnt++;
            $display("FAIL sync_pre got %b want 00", {dut_if.tick[0], dut_if.tick[2]});
        end
        dut_if.sync = 1'b1;
        step();
        dut_if.sync = 1'b0;
        cmp_cnt++;
        if ({dut_if.clk_out, dut_if.tick} !== 8'b0101_0101) begin
            err_cnt++;
            $display("FAIL sync_edge got %b want 01010101", {dut_if.clk_out, dut_if.tick});
        end
        for (int k = 1; k <= 16; k++) begin
            step();
            exp = {(k % 8) == 0, (k % 4) < 2, (k % 4) == 0};
            cmp_cnt++;
            if ({dut_if.tick[0], dut_if.clk_out[2], dut_if.tick[2]} !== exp) begin
                err_cnt++;
                $display("FAIL sync_follow k=%0d got %b want %b", k,
                         {dut_if.tick[0], dut_if.clk_out[2], dut_if.tick[2]}, exp);
            end
        end
        dut_if.en = '0;
        step();
    endtask

    task automatic test_zero_one_two();
        logic [1:0] exp;
        write_div(3, 0);
        step();
        dut_if.div_we = '0;
        dut_if.en[3] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            cmp_cnt++;
            if ({dut_if.clk_out[3], dut_if.tick[3]} !== 2'b00) begin
                err_cnt++;
                $display("FAIL div0 k=%0d got %b want 00", k, {dut_if.clk_out[3], dut_if.tick[3]});
            end
        end
        write_div(3, 1);
        step();
        dut_if.div_we = '0;
        cmp_cnt++;
        if ({dut_if.clk_out[3], dut_if.tick[3]} !== 2'b00) begin
            err_cnt++;
            $display("FAIL div1_load got %b want 00", {dut_if.clk_out[3], dut_if.tick[3]});
        end
        for (int k = 0; k < 5; k++) begin
            step();
            cmp_cnt++;
            if ({dut_if.clk_out[3], dut_if.tick[3]} !== 2'b11) begin
                err_cnt++;
                $display("FAIL div1 k=%0d got %b want 11", k, {dut_if.clk_out[3], dut_if.tick[3]});
            end
        end
        write_div(3, 2);
        for (int k = 0; k < 8; k++) begin
            step();
            dut_if.div_we = '0;
            exp = {(k % 2) == 0, (k % 2) == 0};
            cmp_cnt++;
            if ({dut_if.clk_out[3], dut_if.tick[3]} !== exp) begin
                err_cnt++;
                $display("FAIL div2 k=%0d got %b want %b", k,
                         {dut_if.clk_out[3], dut_if.tick[3]}, exp);
            end
        end
        dut_if.en[3] = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        logic [2:0] exp;
        write_div(1, 6);
        step();
        dut_if.div_we = '0;
        dut_if.en[1] = 1'b1;
        step();
        step();
        step();
        cmp_cnt++;
        if ({dut_if.clk_out[1], dut_if.tick[1]} !== 2'b10) begin
            err_cnt++;
            $display("FAIL div6_cnt2 got %b want 10", {dut_if.clk_out[1], dut_if.tick[1]});
        end
        write_div(1, 9);
        step();
        dut_if.div_we = '0;
        cmp_cnt++;
        if ({dut_if.clk_out[1], dut_if.tick[1], dut_if.busy[1]} !== 3'b001) begin
            err_cnt++;
            $display("FAIL div6_cnt3 got %b want 001",
                     {dut_if.clk_out[1], dut_if.tick[1], dut_if.busy[1]});
        end
        reset = 1'b1;
        #1;
        cmp_cnt++;
        if ({dut_if.clk_out, dut_if.tick, dut_if.busy} !== 12'h000) begin
            err_cnt++;
            $display("FAIL async_reset got %h want 000", {dut_if.clk_out, dut_if.tick, dut_if.busy});
        end
        step();
        reset = 1'b0;
        for (int k = 0; k < 9; k++) begin
            step();
            exp = {(k % 8) < 4, (k % 8) == 0, 1'b0};
            cmp_cnt++;
            if ({dut_if.clk_out[1], dut_if.tick[1], dut_if.busy[1]} !== exp) begin
                err_cnt++;
                $display("FAIL post_reset k=%0d got %b want %b", k,
                         {dut_if.clk_out[1], dut_if.tick[1], dut_if.busy[1]}, exp);
            end
        end
        dut_if.en = '0;
        step();
    endtask

    initial begin
        test_reset();
        test_div8();
        test_div5();
        test_mid_update();
        test_sync();
        test_zero_one_two();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
Multi-channel programmable clock divider. It is the successor to the fixed divide-by-8 toggle divider. Each of NUM_CH channels produces a divided clock-enable waveform, clk_out, from clk, plus a one-cycle tick at each period start. Divisors are runtime-programmable, odd divisors are supported, and divisor changes are glitch-free (they take effect only at a period boundary). A common sync input phase-aligns all channels. The block sits in the clocking/timebase area and feeds slow logic as enables. It is not a clock-tree source.

Parameters:
NUM_CH, 4, number of independent divider channels
DIV_W, 8, divisor width; maximum divisor 2^DIV_W-1
DEFAULT_DIV, 8, active and shadow divisor value after reset, for every channel

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
en  input  NUM_CH  per-channel run enable
div_in  input  NUM_CH*DIV_W  per-channel divisor value; channel i occupies bits [i*DIV_W +: DIV_W]
div_we  input  NUM_CH  per-channel write strobe; div_in[i] is captured into shadow[i]
sync  input  1  restarts every enabled channel's period on this edge
clk_out  output  NUM_CH  divided waveform, registered
tick  output  NUM_CH  one-cycle pulse on the first cycle of each period, registered
busy  output  NUM_CH  high when shadow != active, i.e. an update is pending

Behaviour:
- Per-channel state:
  - cnt[DIV_W], the period position 0..D-1.
  - active[DIV_W], the divisor D in use.
  - shadow[DIV_W], the pending divisor.
- Reset (asynchronous):
  - active = shadow = DEFAULT_DIV.
  - cnt = DEFAULT_DIV-1, the "end of period" position.
  - clk_out = 0, tick = 0, busy = 0.
- Waveform for D >= 2:
  - Period is D cycles, with H = (D+1)>>1.
  - clk_out is 1 while cnt < H and 0 otherwise. For odd D it is high for one more cycle than it is low.
  - clk_out and tick are computed from next-cnt, so they change on the same edge as cnt. Latency from period start to clk_out is 0 cycles.
- Counting with en=1:
  - When cnt == active-1, the boundary: cnt -> 0, tick=1, clk_out=1.
  - Otherwise cnt -> cnt+1 and tick=0.
  - The first enabled edge after reset or re-enable starts a period.
- Divisor update:
  - div_we[i] writes shadow[i] in the same cycle.
  - active <= (div_we ? div_in : shadow) at any boundary edge, so a concurrent write bypasses the shadow.
  - The same load also happens on any edge where en=0.
  - The remainder of an in-flight period always uses the old D. No truncated or stretched pulse is allowed.
- D = 0: the channel is stopped. clk_out=0, tick=0, cnt held at 0. A nonzero write takes effect on the next edge, and a new period starts on the following edge.
- D = 1: clk_out is constant 1 and tick=1 every cycle while enabled.
- en=0: on the next edge cnt -> active-1, clk_out -> 0, tick -> 0. The pending update is loaded.
- sync=1 (en=1): the channel performs a boundary on that edge regardless of cnt. The pending update is loaded, cnt=0, tick=1, clk_out=1. sync with en=0 has no effect.
- Precedence, highest first: reset > en=0 > D==0 > sync > normal boundary > increment.
- busy is registered: busy = (shadow != active) after the edge.
- Channels are fully independent except for the shared sync.

Decomposition:
- Shared package/header clk_div_pkg holds:
  - DIV_W_DEFAULT and DEFAULT_DIV constants.
  - A function half_high(D) returning (D+1)>>1.
- One sub-module, clk_div_chan: a single channel with scalar ports. The top generate-instantiates NUM_CH of these and slices the buses.

Test Plan:
- Reset, then en=1 on ch0 with DEFAULT_DIV=8 -> tick every 8 cycles; clk_out high 4 / low 4; first tick on the first enabled edge.
- Write D=5 on ch1 -> clk_out high 3 / low 2; tick period 5; busy cleared at the first boundary after the write.
- Write D=3 mid-period while D=8 is at cnt=2 -> the current period completes 8 cycles, then 3-cycle periods follow. No glitch: every high/low run length is checked.
- Pulse sync with ch0 D=8 and ch2 D=4 at arbitrary phases -> both ticks assert on the same edge; ch2 ticks coincide with ch0 every 8 cycles thereafter.
- D=0, then D=1, then D=2 on ch3 -> clk_out stuck at 0; then constant 1 with tick every cycle; then alternating 1/0.
- Assert reset mid-period (D=6, cnt=3) -> clk_out=0 and tick=0 immediately; active back to 8; the period restarts on the first edge after reset deasserts.
